// File: rtl/csa_arbiter.sv
// csa_arbiter: round-robin front end that shares one external W-bit adder
// among N requesters. Each requester owns a one-deep result register and a
// stored carry, so it can chain multi-word additions across grants.
module csa_arbiter #(
  parameter int W = 64,
  parameter int N = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  input  logic [N-1:0]   req_cin,
  input  logic [N-1:0]   req_chain,
  output logic [N-1:0]   rsp_valid,
  input  logic [N-1:0]   rsp_ready,
  output logic [N*W-1:0] rsp_s,
  output logic [N-1:0]   rsp_cout,
  output logic [W-1:0]   a,
  output logic [W-1:0]   b,
  output logic           carry_in,
  input  logic [W-1:0]   s,
  input  logic           carry_out,
  output logic [31:0]    grant_count
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  // Result registers, stored carries and arbitration state.
  logic [N-1:0]   vld_p1;
  logic [N*W-1:0] rsp_s_p1;
  logic [N-1:0]   rsp_cout_p1;
  logic [N-1:0]   carry_p1;
  logic [31:0]    grant_cnt_p1;
  logic [IW-1:0]  last_grant_p1;

  // Grant decision for the current cycle.
  logic [N-1:0]   eligible;
  logic [IW:0]    pick;
  logic           grant_vld;
  logic [IW-1:0]  grant_idx;

  // Round-robin search: scan from last+1 around to last; the nearest
  // eligible index wins. Returns {found, index}.
  function automatic logic [IW:0] rr_pick(input logic [N-1:0]  elig,
                                          input logic [IW-1:0] last);
    logic [IW:0] res;
    int          idx;
    res = '0;
    // Walk the distances from far to near so the nearest hit is written last.
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last) + k) % N;
      if (elig[idx]) res = {1'b1, IW'(idx)};
    end
    return res;
  endfunction

  // ---- stage 0: eligibility, arbitration and shared adder operand mux ----
  always_comb begin
    eligible  = req_valid & (~vld_p1 | rsp_ready);
    pick      = rr_pick(eligible, last_grant_p1);
    grant_vld = pick[IW] & ~reset;
    grant_idx = pick[IW-1:0];
    req_ready = '0;
    a         = '0;
    b         = '0;
    carry_in  = 1'b0;
    if (grant_vld) begin
      req_ready[grant_idx] = 1'b1;
      a        = req_a[grant_idx*W +: W];
      b        = req_b[grant_idx*W +: W];
      carry_in = req_chain[grant_idx] ? carry_p1[grant_idx] : req_cin[grant_idx];
    end
  end

  // ---- stage 1: capture adder result for the granted requester ----
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1        <= '0;
      rsp_s_p1      <= '0;
      rsp_cout_p1   <= '0;
      carry_p1      <= '0;
      grant_cnt_p1  <= '0;
      last_grant_p1 <= IW'(N - 1);
    end else begin
      for (int i = 0; i < N; i++) begin
        if (grant_vld && (grant_idx == IW'(i))) begin
          vld_p1[i]            <= 1'b1;
          rsp_s_p1[i*W +: W]   <= s;
          rsp_cout_p1[i]       <= carry_out;
          carry_p1[i]          <= carry_out;
        end else if (rsp_ready[i]) begin
          vld_p1[i] <= 1'b0;
        end
      end
      if (grant_vld) begin
        grant_cnt_p1  <= grant_cnt_p1 + 32'd1;
        last_grant_p1 <= grant_idx;
      end
    end
  end

  assign rsp_valid   = vld_p1;
  assign rsp_s       = rsp_s_p1;
  assign rsp_cout    = rsp_cout_p1;
  assign grant_count = grant_cnt_p1;

endmodule

// File: tb/tb_csa_arbiter.sv
// Bench for csa_arbiter: directed scenarios plus random traffic, checked
// against a queue-based reference model and a decoupled result monitor.
module tb_csa_arbiter;
  localparam int W = 64;
  localparam int N = 4;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0, req_ready, req_cin = '0, req_chain = '0;
  logic [N-1:0]   rsp_valid, rsp_ready = '0, rsp_cout;
  logic [N*W-1:0] req_a = '0, req_b = '0, rsp_s;
  logic [W-1:0]   a, b, s;
  logic           carry_in, carry_out;
  logic [31:0]    grant_count;

  // External shared adder.
  assign {carry_out, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, carry_in};

  csa_arbiter #(.W(W), .N(N)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_chain(req_chain),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_s(rsp_s), .rsp_cout(rsp_cout),
    .a(a), .b(b), .carry_in(carry_in),
    .s(s), .carry_out(carry_out),
    .grant_count(grant_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Staged stimulus, applied shortly after each rising edge.
  logic           nx_reset = 1'b1;
  logic [N-1:0]   nx_valid = '0, nx_cin = '0, nx_chain = '0, nx_rready = '0;
  logic [W-1:0]   nx_a [N];
  logic [W-1:0]   nx_b [N];

  // Reference model state.
  logic [W:0]     q [N][$];
  bit             held [N];
  bit             mcarry [N];
  int             last = N - 1;
  logic [31:0]    mcount = '0;

  task automatic chk(input string nm, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rnd64();
    if ($urandom_range(7) == 0) return '1;
    return {$urandom, $urandom};
  endfunction

  // One clock cycle: apply staged inputs, predict and check the grant,
  // update the model and queue the expected result.
  task automatic step();
    logic [N-1:0] elig, exp_rdy, exp_vld;
    logic [W-1:0] ea, eb;
    logic         ec;
    logic [W:0]   sum;
    int           g, idx;
    @(posedge clock);
    #1;
    reset     = nx_reset;
    req_valid = nx_valid;
    req_cin   = nx_cin;
    req_chain = nx_chain;
    rsp_ready = nx_rready;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = nx_a[i];
      req_b[i*W +: W] = nx_b[i];
    end
    #2;
    if (reset) begin
      chk("rst_req_ready", {{(W+1-N){1'b0}}, req_ready}, '0);
      chk("rst_a", {1'b0, a}, '0);
      chk("rst_b", {1'b0, b}, '0);
      chk("rst_carry_in", {{W{1'b0}}, carry_in}, '0);
      for (int i = 0; i < N; i++) begin
        held[i] = 0;
        mcarry[i] = 0;
        q[i].delete();
      end
      last = N - 1;
      mcount = '0;
    end else begin
      chk("grant_count", {{(W+1-32){1'b0}}, grant_count}, {{(W+1-32){1'b0}}, mcount});
      for (int i = 0; i < N; i++) exp_vld[i] = held[i];
      chk("rsp_valid", {{(W+1-N){1'b0}}, rsp_valid}, {{(W+1-N){1'b0}}, exp_vld});
      for (int i = 0; i < N; i++) elig[i] = req_valid[i] && (!held[i] || rsp_ready[i]);
      g = -1;
      for (int k = 1; k <= N; k++) begin
        idx = (last + k) % N;
        if (g < 0 && elig[idx]) g = idx;
      end
      exp_rdy = '0;
      ea = '0;
      eb = '0;
      ec = 1'b0;
      if (g >= 0) begin
        exp_rdy[g] = 1'b1;
        ea = nx_a[g];
        eb = nx_b[g];
        ec = nx_chain[g] ? mcarry[g] : nx_cin[g];
      end
      chk("req_ready", {{(W+1-N){1'b0}}, req_ready}, {{(W+1-N){1'b0}}, exp_rdy});
      chk("a", {1'b0, a}, {1'b0, ea});
      chk("b", {1'b0, b}, {1'b0, eb});
      chk("carry_in", {{W{1'b0}}, carry_in}, {{W{1'b0}}, ec});
      for (int i = 0; i < N; i++) if (held[i] && rsp_ready[i]) held[i] = 0;
      if (g >= 0) begin
        sum = {1'b0, ea} + {1'b0, eb} + {{W{1'b0}}, ec};
        q[g].push_back(sum);
        held[g] = 1;
        mcarry[g] = sum[W];
        last = g;
        mcount = mcount + 32'd1;
      end
    end
  endtask

  // Result monitor: compare every held result with the oldest expected one.
  always @(negedge clock) begin
    logic [W:0] fr;
    if (reset === 1'b0) begin
      for (int i = 0; i < N; i++) begin
        if (rsp_valid[i] === 1'b1) begin
          if (q[i].size() == 0) begin
            chk($sformatf("rsp_unexpected[%0d]", i), {{W{1'b0}}, rsp_valid[i]}, '0);
          end else begin
            fr = q[i][0];
            chk($sformatf("rsp_s[%0d]", i), {1'b0, rsp_s[i*W +: W]}, {1'b0, fr[W-1:0]});
            chk($sformatf("rsp_cout[%0d]", i), {{W{1'b0}}, rsp_cout[i]}, {{W{1'b0}}, fr[W]});
            if (rsp_ready[i]) void'(q[i].pop_front());
          end
        end
      end
    end
  end

  task automatic set_op(input int i, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic vc, input logic vch);
    nx_a[i] = va;
    nx_b[i] = vb;
    nx_cin[i] = vc;
    nx_chain[i] = vch;
  endtask

  task automatic clear_ops();
    nx_valid = '0;
    nx_cin = '0;
    nx_chain = '0;
    for (int i = 0; i < N; i++) begin
      nx_a[i] = '0;
      nx_b[i] = '0;
    end
  endtask

  initial begin
    logic [31:0] cnt_save;
    clear_ops();
    nx_reset = 1'b1;
    nx_rready = '0;
    repeat (3) step();
    nx_reset = 1'b0;
    step();

    // Single operation on requester 0.
    nx_valid = 4'b0001;
    set_op(0, 64'd5, 64'd7, 1'b1, 1'b0);
    step();
    chk("single_ready", {{(W+1-N){1'b0}}, req_ready}, {{(W+1-N){1'b0}}, 4'b0001});
    clear_ops();
    step();
    chk("single_vld", {{W{1'b0}}, rsp_valid[0]}, {{W{1'b0}}, 1'b1});
    chk("single_s", {1'b0, rsp_s[W-1:0]}, 65'd13);
    chk("single_cout", {{W{1'b0}}, rsp_cout[0]}, '0);
    chk("single_cnt", {{(W+1-32){1'b0}}, grant_count}, 65'd1);
    nx_rready = '1;
    step();

    // Round robin with everyone busy, from a fresh reset.
    nx_reset = 1'b1;
    step();
    nx_reset = 1'b0;
    nx_valid = '1;
    for (int i = 0; i < N; i++) set_op(i, rnd64(), rnd64(), 1'($urandom), 1'b0);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rr_order", {{(W+1-N){1'b0}}, req_ready}, 65'd1 << (k % N));
    end
    clear_ops();
    step();

    // Chain on requester 1.
    nx_valid = 4'b0010;
    set_op(1, '1, 64'd1, 1'b0, 1'b0);
    step();
    set_op(1, '0, '0, 1'b0, 1'b1);
    step();
    chk("chain_cin", {{W{1'b0}}, carry_in}, 65'd1);
    clear_ops();
    step();
    chk("chain_s", {1'b0, rsp_s[1*W +: W]}, 65'd1);
    chk("chain_cout", {{W{1'b0}}, rsp_cout[1]}, '0);
    step();

    // Backpressure on requester 2.
    nx_rready = 4'b1011;
    nx_valid = 4'b0100;
    set_op(2, 64'd100, 64'd23, 1'b0, 1'b0);
    step();
    nx_valid = 4'b0111;
    set_op(0, rnd64(), rnd64(), 1'b0, 1'b0);
    set_op(1, rnd64(), rnd64(), 1'b1, 1'b0);
    set_op(2, 64'd7, 64'd8, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("bp_no_grant2", {{W{1'b0}}, req_ready[2]}, '0);
      chk("bp_hold_s2", {1'b0, rsp_s[2*W +: W]}, 65'd123);
    end
    nx_rready = '1;
    nx_valid = 4'b0100;
    step();
    chk("bp_release", {{(W+1-N){1'b0}}, req_ready}, {{(W+1-N){1'b0}}, 4'b0100});
    clear_ops();
    step();
    chk("bp_new_s2", {1'b0, rsp_s[2*W +: W]}, 65'd15);
    step();

    // Reset in the middle of held results and set carries.
    nx_rready = '0;
    nx_valid = 4'b1010;
    set_op(1, '1, 64'd1, 1'b0, 1'b0);
    set_op(3, '1, 64'd2, 1'b0, 1'b0);
    step();
    step();
    clear_ops();
    step();
    chk("pre_rst_vld", {{(W+1-N){1'b0}}, rsp_valid}, {{(W+1-N){1'b0}}, 4'b1010});
    nx_reset = 1'b1;
    step();
    nx_reset = 1'b0;
    step();
    chk("post_rst_vld", {{(W+1-N){1'b0}}, rsp_valid}, '0);
    chk("post_rst_cnt", {{(W+1-32){1'b0}}, grant_count}, '0);
    nx_valid = 4'b1000;
    set_op(3, '0, '0, 1'b1, 1'b1);
    step();
    chk("post_rst_chain_cin", {{W{1'b0}}, carry_in}, '0);
    clear_ops();
    nx_rready = '1;
    step();

    // Idle.
    cnt_save = grant_count;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("idle_a", {1'b0, a}, '0);
      chk("idle_carry_in", {{W{1'b0}}, carry_in}, '0);
    end
    chk("idle_cnt", {{(W+1-32){1'b0}}, grant_count}, {{(W+1-32){1'b0}}, cnt_save});

    // Random traffic with occasional resets.
    for (int k = 0; k < 500; k++) begin
      nx_reset = ($urandom_range(59) == 0);
      nx_valid = N'($urandom);
      nx_rready = N'($urandom);
      for (int i = 0; i < N; i++)
        set_op(i, rnd64(), rnd64(), 1'($urandom), 1'($urandom));
      step();
    end

    // Drain every held result.
    nx_reset = 1'b0;
    clear_ops();
    nx_rready = '1;
    repeat (4) step();
    @(negedge clock);
    #1;
    for (int i = 0; i < N; i++)
      chk($sformatf("drain_q[%0d]", i), 65'(q[i].size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/csa_arbiter.md
CSA_ARBITER -- requirements
Module: csa_arbiter

Interface
REQ-001 Parameter: W, default 64, adder operand width.
REQ-002 Parameter: N, default 4, number of requesters (2..8).
REQ-003 Port: clock  input  1  single clock; all state changes on posedge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: req_valid  input  N  requester i presents an add operation.
REQ-006 Port: req_ready  output  N  requester i's operation is accepted this cycle (one-hot or zero).
REQ-007 Port: req_a, req_b  input  N*W each  operands; slice i = bits [i*W +: W].
REQ-008 Port: req_cin  input  N  explicit carry-in per requester.
REQ-009 Port: req_chain  input  N  1 = use requester i's stored carry instead of req_cin.
REQ-010 Port: rsp_valid  output  N  result held for requester i.
REQ-011 Port: rsp_ready  input  N  requester i consumes its result.
REQ-012 Port: rsp_s  output  N*W  registered sum per requester.
REQ-013 Port: rsp_cout  output  N  registered carry-out per requester.
REQ-014 Port: a, b  output  W each  shared adder operands.
REQ-015 Port: carry_in  output  1  shared adder carry-in.
REQ-016 Port: s  input  W  shared adder sum, combinational, same cycle.
REQ-017 Port: carry_out  input  1  shared adder carry-out, same cycle.
REQ-018 Port: grant_count  output  32  total accepted operations, wraps at 2^32.

Function
REQ-019 Requester i is eligible when req_valid[i]=1 and (rsp_valid[i]=0 or rsp_ready[i]=1) in the same cycle.
REQ-020 At most one eligible requester is granted per cycle; req_ready is asserted only for the granted index.
REQ-021 Round-robin: search starts at (last_grant+1) mod N; first eligible index wins; last_grant updates only on a grant.
REQ-022 Handshake: an operation transfers when req_valid[i] and req_ready[i] are both 1; req_ready never depends on a future cycle.
REQ-023 In the grant cycle, a/b drive the granted slice of req_a/req_b; carry_in = stored_carry[i] if req_chain[i] else req_cin[i].
REQ-024 No grant: a, b, carry_in drive 0.
REQ-025 Latency: grant in cycle t -> rsp_valid[i]=1 with rsp_s[i]=s, rsp_cout[i]=carry_out sampled at t, visible from t+1.
REQ-026 rsp_valid[i], rsp_s[i], rsp_cout[i] hold until rsp_valid[i]&rsp_ready[i]; then rsp_valid[i] clears next cycle unless a new grant to i occurs in the same cycle, in which case the new result loads, back-to-back, one op per cycle per requester.
REQ-027 stored_carry[i] updates to carry_out on every grant to i; otherwise holds.
REQ-028 rsp_ready[i] with rsp_valid[i]=0 has no effect.
REQ-029 Requests with req_valid=0 are never granted; a non-eligible request waits, without losing its round-robin turn, until eligible.
REQ-030 grant_count increments by 1 per grant; 0xFFFFFFFF + 1 -> 0.
REQ-031 Width rule: sums are W bits plus carry-out; no truncation or extension inside the block.

Reset
REQ-032 While reset=1 at a posedge: rsp_valid=0, rsp_s=0, rsp_cout=0, stored_carry=0, grant_count=0, last_grant=N-1 (requester 0 has first priority).
REQ-033 While reset=1, req_ready=0, a=0, b=0, carry_in=0 combinationally; no grant is taken.
REQ-034 Reset mid-operation discards pending results and stored carries; first grant after reset goes to the lowest eligible index.

Verification
REQ-035 Single: after reset, req0 a=5, b=7, cin=1 -> req_ready[0] same cycle; next cycle rsp_valid[0]=1, rsp_s[0]=13, rsp_cout[0]=0; grant_count=1.
REQ-036 Round robin: all 4 valid continuously, rsp_ready=all 1 -> grant order 0,1,2,3,0,1... one per cycle.
REQ-037 Chain: req1 a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0 -> s=0, cout=1; next op req1 chain=1, a=0, b=0 -> s=1, cout=0.
REQ-038 Backpressure: req2 result held with rsp_ready[2]=0, req2 valid again -> req2 not granted, rsp_s[2] unchanged; others still granted; raising rsp_ready[2] -> req2 granted same cycle, new result next cycle.
REQ-039 Reset mid-stream: reset pulsed with rsp_valid=0b1010 and stored carries set -> all zero next cycle; chain op on req3 then uses carry_in=0.
REQ-040 Idle: no req_valid for 10 cycles -> a=b=0, carry_in=0, grant_count unchanged.
